// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-style control FSM: FETCH/DECODE plus per-class execute states, outputs decoded from state.
// Optional: define BNE_INSTR_EN to decode opcode 0x05 (BNE) through the BRANCH state with inverted zero.
module multicycle_control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_e state_q, state_d;
  // run_q stays low from reset until the first clock edge after release, so
  // outputs and state advance both resume on that edge rather than at release.
  logic   run_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:      state_d = S_EXECUTE;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ:        state_d = S_BRANCH;
`ifdef BNE_INSTR_EN
          OP_BNE:        state_d = S_BRANCH;
`endif
          OP_ADDI:       state_d = S_ADDIEX;
          OP_J:          state_d = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
`ifdef BNE_INSTR_EN
        pc_en     = (opcode == OP_BNE) ? ~zero : zero;
`else
        pc_en     = zero;
`endif
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = 2'b10;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Held in reset or waiting for the first edge after release: all quiet.
    if (!run_q) begin
      state_d    = S_FETCH;
      pc_en      = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      pc_src     = 2'b00;
      illegal_op = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: driver pushes hand-computed per-cycle state/output vectors, monitor pops and compares.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg;
  logic       alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  multicycle_control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // Output vector: {pc_en,i_or_d,mem_read,mem_write,ir_write,reg_write,reg_dst,mem_to_reg,
  //                 alu_src_a,alu_src_b[1:0],alu_op[1:0],pc_src[1:0],illegal_op}
  localparam logic [15:0] PCEN = 16'h8000, IORD = 16'h4000, MRD = 16'h2000, MWR = 16'h1000;
  localparam logic [15:0] IRW = 16'h0800, RW = 16'h0400, RDST = 16'h0200, M2R = 16'h0100;
  localparam logic [15:0] SRCA = 16'h0080, SRCB_4 = 16'h0020, SRCB_IMM = 16'h0040, SRCB_SH = 16'h0060;
  localparam logic [15:0] OP_SUB = 16'h0008, OP_F = 16'h0010, PCS_AO = 16'h0002, PCS_J = 16'h0004;
  localparam logic [15:0] ILL = 16'h0001;
  localparam logic [15:0] FETCH_O = MRD | SRCB_4 | IRW | PCEN;
  localparam logic [15:0] FETCHW_O = MRD | SRCB_4;
  localparam logic [15:0] BR_O = SRCA | OP_SUB | PCS_AO;

  wire [15:0] act = {pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
                     alu_src_a, alu_src_b, alu_op, pc_src, illegal_op};

  typedef struct packed {
    logic [7:0]  id;
    logic [3:0]  st;
    logic [15:0] ov;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_pass = 0, nid = 0;
  logic probe = 1'b0;

  task automatic push(input logic [3:0] st, input logic [15:0] ov);
    exp_t e;
    e.id = nid[7:0]; e.st = st; e.ov = ov;
    sb.push_back(e);
    nid++;
  endtask

  task automatic step(input logic [5:0] op, input logic z, input logic mr,
                      input logic [3:0] st, input logic [15:0] ov);
    @(posedge clk); #1;
    opcode = op; zero = z; mem_ready = mr;
    push(st, ov);
  endtask

  // Monitor: compares on every falling edge, and on demand for mid-cycle events.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or posedge probe);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_chk++;
        if (state === e.st && act === e.ov) n_pass++;
        else $display("FAIL step%0d: state=%0d outs=%h, expected state=%0d outs=%h",
                      e.id, state, act, e.st, e.ov);
      end
    end
  end

  initial begin
    // Held in reset: everything zero.
    step(6'h00, 0, 1, 4'd0, 16'h0000);
    step(6'h00, 0, 1, 4'd0, 16'h0000);
    @(negedge clk); #1 reset = 1'b1;
    // R-type
    step(6'h00, 0, 1, 4'd0, FETCH_O);
    step(6'h00, 0, 1, 4'd1, SRCB_SH);
    step(6'h00, 0, 1, 4'd6, SRCA | OP_F);
    step(6'h00, 0, 1, 4'd7, RW | RDST);
    // LW with one FETCH wait and three MEMRD waits
    step(6'h23, 0, 0, 4'd0, FETCHW_O);
    step(6'h23, 0, 1, 4'd0, FETCH_O);
    step(6'h23, 0, 1, 4'd1, SRCB_SH);
    step(6'h23, 0, 1, 4'd2, SRCA | SRCB_IMM);
    step(6'h23, 0, 0, 4'd3, MRD | IORD);
    step(6'h23, 0, 0, 4'd3, MRD | IORD);
    step(6'h23, 0, 0, 4'd3, MRD | IORD);
    step(6'h23, 0, 1, 4'd3, MRD | IORD);
    step(6'h23, 0, 1, 4'd4, RW | M2R);
    // SW
    step(6'h2B, 0, 1, 4'd0, FETCH_O);
    step(6'h2B, 0, 1, 4'd1, SRCB_SH);
    step(6'h2B, 0, 1, 4'd2, SRCA | SRCB_IMM);
    step(6'h2B, 0, 1, 4'd5, MWR | IORD);
    // BEQ taken, then not taken
    step(6'h04, 1, 1, 4'd0, FETCH_O);
    step(6'h04, 1, 1, 4'd1, SRCB_SH);
    step(6'h04, 1, 1, 4'd8, BR_O | PCEN);
    step(6'h04, 0, 1, 4'd0, FETCH_O);
    step(6'h04, 0, 1, 4'd1, SRCB_SH);
    step(6'h04, 0, 1, 4'd8, BR_O);
    // ADDI
    step(6'h08, 0, 1, 4'd0, FETCH_O);
    step(6'h08, 0, 1, 4'd1, SRCB_SH);
    step(6'h08, 0, 1, 4'd9, SRCA | SRCB_IMM);
    step(6'h08, 0, 1, 4'd10, RW);
    // BNE: optional decode, otherwise illegal
    step(6'h05, 0, 1, 4'd0, FETCH_O);
`ifdef BNE_INSTR_EN
    step(6'h05, 0, 1, 4'd1, SRCB_SH);
    step(6'h05, 0, 1, 4'd8, BR_O | PCEN);
`else
    step(6'h05, 0, 1, 4'd1, SRCB_SH | ILL);
`endif
    // J
    step(6'h02, 0, 1, 4'd0, FETCH_O);
    step(6'h02, 0, 1, 4'd1, SRCB_SH);
    step(6'h02, 0, 1, 4'd11, PCS_J | PCEN);
    // SW stalled in MEMWR, then reset asserted mid-cycle
    step(6'h2B, 0, 1, 4'd0, FETCH_O);
    step(6'h2B, 0, 1, 4'd1, SRCB_SH);
    step(6'h2B, 0, 1, 4'd2, SRCA | SRCB_IMM);
    step(6'h2B, 0, 0, 4'd5, MWR | IORD);
    @(negedge clk); #1 reset = 1'b0;
    #1 push(4'd0, 16'h0000);
    probe = 1'b1;
    #1 probe = 1'b0;
    step(6'h2B, 0, 1, 4'd0, 16'h0000);
    step(6'h2B, 0, 1, 4'd0, 16'h0000);
    @(negedge clk); #1 reset = 1'b1;
    // Illegal opcode after reset release, then back to FETCH
    step(6'h3F, 0, 1, 4'd0, FETCH_O);
    step(6'h3F, 0, 1, 4'd1, SRCB_SH | ILL);
    step(6'h3F, 0, 1, 4'd0, FETCH_O);
    step(6'h3F, 0, 1, 4'd1, SRCB_SH | ILL);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
